// File: rtl/instr_encoder.sv
// Control-bundle encoder: {opcode, operand} words -> FIFO -> MSB-first serial link.
// Define INSTR_ENCODER_PARITY_EN to append an even-parity bit to every frame.
module instr_encoder #(
    parameter int OPW   = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     bez_i,
    input  logic                     ja_i,
    input  logic                     alu_fun_i,
    input  logic                     op1_i,
    input  logic                     op2_i,
    input  logic                     write_reg_i,
    input  logic                     write_x8_i,
    input  logic [1:0]               x8_sel_i,
    input  logic [OPW-1:0]           operand_i,
    input  logic                     ser_en_i,
    output logic                     ser_data_o,
    output logic                     ser_valid_o,
    output logic                     ser_last_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int W  = 3 + OPW;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef INSTR_ENCODER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int CW = $clog2(FL);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e          state_q, state_d;
    logic [FL-1:0]   shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            err_q, err_d;

    logic [8:0]      ctl;
    logic [2:0]      opc;
    logic            legal;
    logic [W-1:0]    word;
    logic [W-1:0]    head;
    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;

    // Exact-match reverse decode; anything outside the table is illegal.
    always_comb begin
        ctl   = {bez_i, ja_i, alu_fun_i, op1_i, op2_i,
                 write_reg_i, write_x8_i, x8_sel_i};
        legal = 1'b1;
        opc   = 3'd0;
        case (ctl)
            9'b100010000: opc = 3'd0;
            9'b000000101: opc = 3'd1;
            9'b000000000: opc = 3'd2;
            9'b000100110: opc = 3'd3;
            9'b010110000: opc = 3'd4;
            9'b000000100: opc = 3'd5;
            9'b000001000: opc = 3'd6;
            9'b001100110: opc = 3'd7;
            default:      legal = 1'b0;
        endcase
    end

    assign word   = {opc, operand_i};
    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign accept = in_valid_i & ~full;
    assign push   = accept & legal;
    assign err_d  = accept & ~legal;
    assign head   = mem_q[rd_ptr_q];

    // Serializer next state; a finished frame reloads on the same edge.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pop = ~empty;
            end
            S_SHIFT: begin
                if (ser_en_i) begin
                    if (cnt_q == '0) begin
                        if (empty) begin
                            state_d = S_IDLE;
                        end else begin
                            pop = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[FL-2:0], 1'b0};
                        cnt_d   = cnt_q - CW'(1);
                    end
                end
            end
        endcase
        if (pop) begin
            state_d = S_SHIFT;
`ifdef INSTR_ENCODER_PARITY_EN
            shift_d = {head, ^head};
`else
            shift_d = head;
`endif
            cnt_d   = CW'(FL - 1);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign in_ready_o  = ~full;
    assign ser_valid_o = (state_q == S_SHIFT);
    assign ser_data_o  = (state_q == S_SHIFT) & shift_q[FL-1];
    assign ser_last_o  = (state_q == S_SHIFT) & (cnt_q == '0);
    assign err_o       = err_q;
    assign level_o     = level_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a
// randomized run against a queue-based frame model.
module tb_instr_encoder;

    localparam int OPW   = 5;
    localparam int DEPTH = 4;
    localparam int W     = 3 + OPW;
`ifdef INSTR_ENCODER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       bez, ja, alu_fun, op1, op2, write_reg, write_x8;
    logic [1:0] x8_sel;
    logic [4:0] operand;
    logic       ser_en;
    logic       ser_data, ser_valid, ser_last, err;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    logic [8:0] tbl [8];

    always #5 clk = ~clk;

    instr_encoder #(.OPW(OPW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .bez_i(bez), .ja_i(ja), .alu_fun_i(alu_fun),
        .op1_i(op1), .op2_i(op2), .write_reg_i(write_reg),
        .write_x8_i(write_x8), .x8_sel_i(x8_sel),
        .operand_i(operand), .ser_en_i(ser_en),
        .ser_data_o(ser_data), .ser_valid_o(ser_valid),
        .ser_last_o(ser_last), .err_o(err), .level_o(level)
    );

    // Bit i of the frame carrying word w, first bit transmitted is i=0.
    function automatic logic fbit(input logic [7:0] w, input int i);
        if (i < W) return w[W-1-i];
        return ^w;
    endfunction

    function automatic int lookup(input logic [8:0] b);
        for (int k = 0; k < 8; k++) if (tbl[k] == b) return k;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] b, input logic [4:0] o);
        {bez, ja, alu_fun, op1, op2, write_reg, write_x8, x8_sel} = b;
        operand = o;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; ser_en = 1'b0;
        drive(9'd0, 5'd0);
        step(); step();
        reset = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d exp 0", level); end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", ser_valid); end
        checks++; if (ser_data !== 1'b0) begin failures++; $display("FAIL reset_data: got %b exp 0", ser_data); end
        checks++; if (ser_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b exp 0", ser_last); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", err); end
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_li();
        logic [7:0] w;
        w = {3'd1, 5'h0A};
        drive(tbl[1], 5'h0A); in_valid = 1'b1; ser_en = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL li_latency: got %b exp 0", ser_valid); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL li_level: got %0d exp 1", level); end
        step();
        for (int i = 0; i < FL; i++) begin
            checks++; if (ser_valid !== 1'b1) begin failures++; $display("FAIL li_valid[%0d]: got %b exp 1", i, ser_valid); end
            checks++; if (ser_data !== fbit(w, i)) begin failures++; $display("FAIL li_bit[%0d]: got %b exp %b", i, ser_data, fbit(w, i)); end
            checks++; if (ser_last !== (i == FL - 1)) begin failures++; $display("FAIL li_last[%0d]: got %b exp %b", i, ser_last, (i == FL - 1)); end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL li_err[%0d]: got %b exp 0", i, err); end
            step();
        end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL li_end: got %b exp 0", ser_valid); end
    endtask

    task automatic test_fill_back_to_back();
        logic [7:0] ws [5];
        logic [2:0] op;
        logic [4:0] o;
        ser_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                op = 3'($urandom_range(0, 7));
                o  = 5'($urandom);
                ws[k] = {op, o};
                drive(tbl[op], o);
            end else if (k == 5) begin
                drive(tbl[2], 5'h15);
            end else begin
                drive(9'b110000000, 5'h00);
            end
            in_valid = 1'b1;
            checks++; if (in_ready !== (k < 5)) begin failures++; $display("FAIL fill_ready[%0d]: got %b exp %b", k, in_ready, (k < 5)); end
            step();
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL fill_err[%0d]: got %b exp 0", k, err); end
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_level: got %0d exp 4", level); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_full: got %b exp 0", in_ready); end
        ser_en = 1'b1;
        for (int i = 0; i < 5 * FL; i++) begin
            checks++; if (ser_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b exp 1", i, ser_valid); end
            checks++; if (ser_data !== fbit(ws[i / FL], i % FL)) begin failures++; $display("FAIL b2b_bit[%0d]: got %b exp %b", i, ser_data, fbit(ws[i / FL], i % FL)); end
            checks++; if (ser_last !== (i % FL == FL - 1)) begin failures++; $display("FAIL b2b_last[%0d]: got %b exp %b", i, ser_last, (i % FL == FL - 1)); end
            step();
        end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b exp 0", ser_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL b2b_level: got %0d exp 0", level); end
    endtask

    task automatic test_illegal();
        ser_en = 1'b1;
        drive(9'b110000000, 5'h03); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b exp 1", err); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL ill_level: got %0d exp 0", level); end
        step();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_pulse: got %b exp 0", err); end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL ill_frame: got %b exp 0", ser_valid); end
        step();
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL ill_frame2: got %b exp 0", ser_valid); end
    endtask

    task automatic test_hold();
        logic [7:0] w;
        logic [3:0] pat;
        int idx;
        int c;
        w = {3'd7, 5'h1F};
        pat = 4'b1001;
        drive(tbl[7], 5'h1F); in_valid = 1'b1; ser_en = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        idx = 0; c = 0;
        while (idx < FL && c < 64) begin
            ser_en = pat[c % 4];
            checks++; if (ser_valid !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d]: got %b exp 1", c, ser_valid); end
            checks++; if (ser_data !== fbit(w, idx)) begin failures++; $display("FAIL hold_bit[%0d]: got %b exp %b", c, ser_data, fbit(w, idx)); end
            checks++; if (ser_last !== (idx == FL - 1)) begin failures++; $display("FAIL hold_last[%0d]: got %b exp %b", c, ser_last, (idx == FL - 1)); end
            step();
            if (ser_en) idx++;
            c++;
        end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL hold_end: got %b exp 0", ser_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] ws [3];
        logic [2:0] op;
        logic [4:0] o;
        for (int k = 0; k < 3; k++) begin
            op = 3'($urandom_range(0, 7));
            o  = 5'($urandom);
            ws[k] = {op, o};
        end
        ser_en = 1'b1; in_valid = 1'b1;
        drive(tbl[ws[0][7:5]], ws[0][4:0]);
        step();
        drive(tbl[ws[1][7:5]], ws[1][4:0]);
        step();
        checks++; if (ser_data !== fbit(ws[0], 0)) begin failures++; $display("FAIL mid_bit0: got %b exp %b", ser_data, fbit(ws[0], 0)); end
        drive(tbl[ws[2][7:5]], ws[2][4:0]);
        step();
        in_valid = 1'b0;
        checks++; if (ser_data !== fbit(ws[0], 1)) begin failures++; $display("FAIL mid_bit1: got %b exp %b", ser_data, fbit(ws[0], 1)); end
        step();
        checks++; if (ser_data !== fbit(ws[0], 2)) begin failures++; $display("FAIL mid_bit2: got %b exp %b", ser_data, fbit(ws[0], 2)); end
        step();
        checks++; if (level !== 3'd2) begin failures++; $display("FAIL mid_level: got %0d exp 2", level); end
        checks++; if (ser_valid !== 1'b1) begin failures++; $display("FAIL mid_valid: got %b exp 1", ser_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level: got %0d exp 0", level); end
        checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", ser_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b exp 1", in_ready); end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++; if (ser_valid !== 1'b0) begin failures++; $display("FAIL rst_quiet[%0d]: got %b exp 0", i, ser_valid); end
        end
    endtask

    task automatic test_random();
        logic [7:0] mq [$];
        logic       fb [$];
        logic       err_m;
        logic [8:0] b;
        logic [4:0] o;
        logic [7:0] w;
        logic       acc;
        int         op;
        reset = 1'b1; in_valid = 1'b0; ser_en = 1'b0;
        step();
        reset = 1'b0;
        err_m = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            checks++; if (ser_valid !== (fb.size() != 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %b exp %b", cyc, ser_valid, (fb.size() != 0)); end
            if (fb.size() != 0) begin
                checks++; if (ser_data !== fb[0]) begin failures++; $display("FAIL rnd_bit@%0d: got %b exp %b", cyc, ser_data, fb[0]); end
                checks++; if (ser_last !== (fb.size() == 1)) begin failures++; $display("FAIL rnd_last@%0d: got %b exp %b", cyc, ser_last, (fb.size() == 1)); end
            end
            checks++; if (level !== 3'(mq.size())) begin failures++; $display("FAIL rnd_level@%0d: got %0d exp %0d", cyc, level, mq.size()); end
            checks++; if (in_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready@%0d: got %b exp %b", cyc, in_ready, (mq.size() < DEPTH)); end
            checks++; if (err !== err_m) begin failures++; $display("FAIL rnd_err@%0d: got %b exp %b", cyc, err, err_m); end

            in_valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 8) b = tbl[$urandom_range(0, 7)];
            else b = 9'($urandom);
            o = 5'($urandom);
            drive(b, o);
            ser_en = ($urandom_range(0, 9) < 7);

            acc = in_valid && (mq.size() < DEPTH);
            if (fb.size() != 0 && ser_en) void'(fb.pop_front());
            if (fb.size() == 0 && mq.size() != 0) begin
                w = mq.pop_front();
                for (int i = 0; i < FL; i++) fb.push_back(fbit(w, i));
            end
            op = lookup(b);
            if (acc && op >= 0) mq.push_back({3'(op), o});
            err_m = acc && (op < 0);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = 9'b100010000;
        tbl[1] = 9'b000000101;
        tbl[2] = 9'b000000000;
        tbl[3] = 9'b000100110;
        tbl[4] = 9'b010110000;
        tbl[5] = 9'b000000100;
        tbl[6] = 9'b000001000;
        tbl[7] = 9'b001100110;
        test_reset();
        test_li();
        test_fill_back_to_back();
        test_illegal();
        test_hold();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
